spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
SPI slave front-end and sequencer for the 256x8 SPI RAM block.
- Deserialises MOSI frames into 10-bit command words (2-bit command + 8-bit address/data).
- Presents each word to the RAM with a one-cycle rx_valid strobe.
- Returns read data on MISO after a read-data command.
- Tracks the read-address/read-data ordering between frames.

Parameters:
FRAME_W, 10, command word width (2 cmd bits + DATA_W)
DATA_W, 8, RAM data/address width

Ports:
clk  input  1  system clock; SPI bits are sampled on its rising edge
rst  input  1  synchronous, active-high reset
ss_n  input  1  slave select, active low, frames one transaction
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, MSB first, registered
rx_data  output  FRAME_W  assembled command word to RAM din
rx_valid  output  1  one-cycle strobe, rx_data valid
tx_data  input  DATA_W  RAM read data (dout)
tx_valid  input  1  RAM read-data valid

Behaviour:
- Single clock domain clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE; miso=0; rx_data=0; rx_valid=0.
  - bit counter=0; rd_addr_done=0; tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: ss_n=0 -> CHK_CMD. Otherwise stay.
- CHK_CMD: mosi (frame bit 9) is shifted in and counter is set to 1. Next state:
  - mosi=0 -> WRITE
  - mosi=1 and rd_addr_done=0 -> READ_ADD
  - mosi=1 and rd_addr_done=1 -> READ_DATA
- WRITE / READ_ADD / READ_DATA, receive phase:
  - One mosi bit shifted per cycle while ss_n=0, until 10 bits are held.
  - The cycle after the 10th bit is sampled: rx_data = frame and rx_valid=1 for exactly one cycle.
- Latency: ss_n fall to rx_valid is 11 cycles (10 sample cycles + 1 register cycle).
- rd_addr_done update, on the rx_valid cycle, from the received bits [9:8]:
  - 10 -> set to 1
  - 11 -> cleared to 0
  - 00/01 -> unchanged
- After rx_valid in WRITE or READ_ADD: hold until ss_n=1, ignore mosi, no further rx_valid in this frame.
- READ_DATA, after rx_valid:
  - Wait for the first cycle (strictly after the rx_valid cycle) with tx_valid=1; latch tx_data into the tx shift register.
  - Next 8 cycles: drive miso = tx_data[7], [6], ..., [0], one bit per cycle.
  - Then miso=0; hold until ss_n=1.
  - RAM latency is 1 cycle, so the first miso bit appears 2 cycles after rx_valid.
- miso=0 in every state and phase other than the READ_DATA transmit phase.
- ss_n=1 in any non-IDLE state -> IDLE on the next cycle; counter cleared; miso=0.
  - Mid-frame abort: no rx_valid and rd_addr_done unchanged.
  - Abort during transmit truncates the output.
- ss_n re-asserted before an abort returns to IDLE has no effect until IDLE is reached; the earliest new frame is CHK_CMD one cycle later.
- A tx_valid that is still high from an earlier read before READ_DATA is entered is ignored; only tx_valid after this frame's rx_valid is used.
- rst asserted mid-frame overrides everything on that edge.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA)
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - FRAME_W/DATA_W defaults
- One natural sub-module: spi_shift_reg, a parameterised SIPO/PISO with load, shift and count, used for both rx and tx paths.
- FSM and rd_addr_done stay in the top.

Test Plan:
- Write address, ss_n low, mosi 00_0000_0101 -> rx_valid 1 cycle at cycle 11 with rx_data=10'h005; miso stays 0.
- Write data, frame 01_1010_1010 -> rx_data=10'h1AA, one rx_valid pulse, rd_addr_done stays 0.
- Read address 10_0000_0101, then new frame 11_xxxx_xxxx:
  - first frame in READ_ADD; rd_addr_done=1 after its rx_valid
  - second frame in READ_DATA; rx_data[9:8]=11
  - tx_valid=1 with tx_data=8'hAA -> miso 1,0,1,0,1,0,1,0 over 8 cycles; rd_addr_done=0
- Back-to-back READ_DATA without a preceding READ_ADD -> FSM routes first bit 1 to READ_ADD (rd_addr_done=0).
- Abort: ss_n=1 after 5 bits -> IDLE next cycle, no rx_valid, rd_addr_done unchanged.
- rst=1 during READ_DATA transmit -> next cycle miso=0, rx_valid=0, state IDLE, rd_addr_done=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end of the 256x8 SPI RAM.
package spi_pkg;

  localparam int DEF_FRAME_W = 10;
  localparam int DEF_DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Sub-phase inside WRITE / READ_ADD / READ_DATA.
  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_TX,
    PH_HOLD
  } phase_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// SPI pins, RAM-side word interface and FSM debug view of spi_slave_ctrl.
interface spi_slave_ctrl_if import spi_pkg::*; #(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int DATA_W  = DEF_DATA_W
) ();

  // Handshake: rx_valid is a one-cycle strobe qualifying rx_data, with no
  // back-pressure; tx_valid qualifies tx_data in the cycle it is high and is
  // only honoured after the read-data frame's rx_valid cycle.
  logic               ss_n;
  logic               mosi;
  logic               miso;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  state_t             state;
  logic               rd_addr_done;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid, state, rd_addr_done
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid, state, rd_addr_done
  );

endinterface

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with parallel load and shift counter (SIPO/PISO).
module spi_shift_reg #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          shift,
  input  logic          sin,
  input  logic [W-1:0]  pdata,
  output logic [W-1:0]  q,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q     <= '0;
      count <= '0;
    end else if (load) begin
      q     <= pdata;
      count <= '0;
    end else if (shift) begin
      q     <= {q[W-2:0], sin};
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave sequencer: frames MOSI into command words for the RAM and
// returns read data on MISO, tracking read-address/read-data ordering.
module spi_slave_ctrl import spi_pkg::*; #(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input logic             clk,
  input logic             rst,
  spi_slave_ctrl_if.slave bus
);

  localparam int RX_CW = $clog2(FRAME_W + 1);
  localparam int TX_CW = $clog2(DATA_W + 1);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(FRAME_W);
  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(DATA_W);

  state_t             state;
  phase_t             phase;
  logic               rd_addr_done;
  logic               rx_valid_r;
  logic [FRAME_W-1:0] rx_data_r;
  logic [FRAME_W-1:0] rx_q;
  logic [RX_CW-1:0]   rx_cnt;
  logic [DATA_W-1:0]  tx_q;
  logic [TX_CW-1:0]   tx_cnt;
  logic [1:0]         rx_cmd;
  logic               abort;
  logic               in_frame;
  logic               sr_clr;
  logic               rx_shift;
  logic               tx_load;
  logic               tx_shift;
  logic               unused_tx_low;

  assign abort    = (state != IDLE) && bus.ss_n;
  assign in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign sr_clr   = (state == IDLE) || abort;
  assign rx_cmd   = rx_q[FRAME_W-1 -: 2];

  assign rx_shift = !bus.ss_n &&
                    ((state == CHK_CMD) || (in_frame && phase == PH_RX && rx_cnt != RX_FULL));
  // The rx_valid cycle itself is excluded so a lingering tx_valid is not taken.
  assign tx_load  = !bus.ss_n && state == READ_DATA && phase == PH_WAIT &&
                    bus.tx_valid && !rx_valid_r;
  assign tx_shift = !bus.ss_n && state == READ_DATA && phase == PH_TX && tx_cnt != TX_FULL;

  spi_shift_reg #(.W(FRAME_W), .CW(RX_CW)) u_rx_sr (
    .clk   (clk),
    .rst   (rst),
    .clr   (sr_clr),
    .load  (1'b0),
    .shift (rx_shift),
    .sin   (bus.mosi),
    .pdata ('0),
    .q     (rx_q),
    .count (rx_cnt)
  );

  // miso is the tx register MSB; zero-fill empties it after the last bit.
  spi_shift_reg #(.W(DATA_W), .CW(TX_CW)) u_tx_sr (
    .clk   (clk),
    .rst   (rst),
    .clr   (sr_clr),
    .load  (tx_load),
    .shift (tx_shift),
    .sin   (1'b0),
    .pdata (bus.tx_data),
    .q     (tx_q),
    .count (tx_cnt)
  );

  assign unused_tx_low = ^tx_q[DATA_W-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_RX;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (abort) begin
        state <= IDLE;
        phase <= PH_RX;
      end else begin
        case (state)
          IDLE: begin
            phase <= PH_RX;
            if (!bus.ss_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!bus.mosi)        state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          default: begin
            case (phase)
              PH_RX: begin
                if (rx_cnt == RX_FULL) begin
                  rx_data_r  <= rx_q;
                  rx_valid_r <= 1'b1;
                  case (rx_cmd)
                    CMD_RD_ADDR: rd_addr_done <= 1'b1;
                    CMD_RD_DATA: rd_addr_done <= 1'b0;
                    default: ;
                  endcase
                  phase <= (state == READ_DATA) ? PH_WAIT : PH_HOLD;
                end
              end
              PH_WAIT: if (tx_load) phase <= PH_TX;
              PH_TX:   if (tx_cnt == TX_FULL) phase <= PH_HOLD;
              PH_HOLD: phase <= PH_HOLD;
            endcase
          end
        endcase
      end
    end
  end

  assign bus.miso         = tx_q[DATA_W-1];
  assign bus.rx_data      = rx_data_r;
  assign bus.rx_valid     = rx_valid_r;
  assign bus.state        = state;
  assign bus.rd_addr_done = rd_addr_done;

endmodule
